// File: rtl/spi_frame_tx.sv
// SPI-slave mode-0 transmitter: header byte, BRAM frame, optional CRC-8 (SPI_TX_CRC_EN), then fill bytes on MISO.
// MSB valid within 3 sys_clk of CS fall; the next BRAM byte is prefetched so every load is immediate.
module spi_frame_tx #(
    parameter int          FRAME_BYTES = 76800,
    parameter int          ADDR_W      = 17,
    parameter logic [7:0]  HDR_ACK     = 8'hA5,
    parameter logic [7:0]  HDR_NACK    = 8'h00,
    parameter logic [7:0]  FILL_BYTE   = 8'hFF
) (
    input  logic              sys_clk,
    input  logic              sys_rst_n,
    input  logic              spi_sclk,
    input  logic              spi_cs_n,
    output logic              spi_miso,
    output logic              spi_miso_oe,
    input  logic              frame_ready,
    output logic [ADDR_W-1:0] bram_rd_addr,
    input  logic [7:0]        bram_rd_data,
    output logic              tx_busy,
    output logic              tx_done,
    output logic              tx_abort
);
    typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, FILL = 2'd2} state_t;

    localparam int               CNT_W    = $clog2(FRAME_BYTES + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(FRAME_BYTES);
    localparam logic [CNT_W-1:0] LAST_M1  = CNT_W'(FRAME_BYTES - 1);

    state_t             state, state_nxt;
    logic [2:0]         sclk_sync, cs_sync;
    logic               sclk_rise, sclk_fall, cs_fall, cs_rise, cs_act;
    logic [7:0]         shreg, pf;
    logic [2:0]         bit_cnt;
    logic               byte_end, ack, done_seen, frame_end, to_fill;
    logic [1:0]         rd_pend;
    logic [CNT_W-1:0]   frame_cnt;
    logic [ADDR_W-1:0]  addr;

`ifdef SPI_TX_CRC_EN
    logic [7:0] crc;
    logic       crc_sent;

    function automatic logic [7:0] crc8_next(input logic [7:0] c, input logic [7:0] d);
        logic [7:0] r;
        r = c ^ d;
        for (int i = 0; i < 8; i++) r = r[7] ? ({r[6:0], 1'b0} ^ 8'h07) : {r[6:0], 1'b0};
        return r;
    endfunction

    assign frame_end = ack && (frame_cnt == LAST_CNT) && crc_sent;
`else
    assign frame_end = ack && (frame_cnt == LAST_CNT);
`endif

    assign to_fill   = !ack || frame_end;
    // bits [1:0] are the synchroniser, bit [2] is the edge-detect history
    assign sclk_rise = sclk_sync[1] & ~sclk_sync[2];
    assign sclk_fall = ~sclk_sync[1] & sclk_sync[2];
    assign cs_fall   = ~cs_sync[1] & cs_sync[2];
    assign cs_rise   = cs_sync[1] & ~cs_sync[2];
    assign cs_act    = ~cs_sync[1];

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            sclk_sync <= 3'b000;
            cs_sync   <= 3'b111;
        end else begin
            sclk_sync <= {sclk_sync[1:0], spi_sclk};
            cs_sync   <= {cs_sync[1:0], spi_cs_n};
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) state <= IDLE;
        else            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (cs_rise) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE:    if (cs_fall) state_nxt = SHIFT;
                SHIFT:   if (sclk_fall && byte_end && to_fill) state_nxt = FILL;
                FILL:    state_nxt = FILL;
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_comb begin
        tx_busy      = (state != IDLE);
        spi_miso_oe  = cs_act;
        spi_miso     = cs_act & shreg[7];
        bram_rd_addr = addr;
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            shreg     <= 8'h00;
            pf        <= 8'h00;
            bit_cnt   <= 3'd0;
            byte_end  <= 1'b0;
            ack       <= 1'b0;
            done_seen <= 1'b0;
            rd_pend   <= 2'b00;
            frame_cnt <= '0;
            addr      <= '0;
            tx_done   <= 1'b0;
            tx_abort  <= 1'b0;
`ifdef SPI_TX_CRC_EN
            crc       <= 8'h00;
            crc_sent  <= 1'b0;
`endif
        end else begin
            tx_done  <= 1'b0;
            tx_abort <= 1'b0;
            rd_pend  <= {rd_pend[0], 1'b0};
            if (rd_pend[1]) pf <= bram_rd_data;

            if (cs_rise) begin
                tx_abort  <= (state != IDLE) && !done_seen;
                addr      <= '0;
                bit_cnt   <= 3'd0;
                byte_end  <= 1'b0;
                frame_cnt <= '0;
                done_seen <= 1'b0;
                rd_pend   <= 2'b00;
`ifdef SPI_TX_CRC_EN
                crc       <= 8'h00;
                crc_sent  <= 1'b0;
`endif
            end else if (state == IDLE) begin
                if (cs_fall) begin
                    ack     <= frame_ready;
                    shreg   <= frame_ready ? HDR_ACK : HDR_NACK;
                    addr    <= '0;
                    rd_pend <= {rd_pend[0], frame_ready};
                end
            end else begin
                if (sclk_rise) begin
                    bit_cnt <= bit_cnt + 3'd1;
                    if (bit_cnt == 3'd7) begin
                        byte_end <= 1'b1;
                        if (state == SHIFT && frame_end) begin
                            tx_done   <= 1'b1;
                            done_seen <= 1'b1;
                        end
                    end
                end
                if (sclk_fall) begin
                    if (byte_end) begin
                        byte_end <= 1'b0;
                        if (to_fill) begin
                            shreg <= FILL_BYTE;
`ifdef SPI_TX_CRC_EN
                        end else if (frame_cnt == LAST_CNT) begin
                            shreg    <= crc;
                            crc_sent <= 1'b1;
`endif
                        end else begin
                            shreg     <= pf;
                            frame_cnt <= frame_cnt + CNT_W'(1);
`ifdef SPI_TX_CRC_EN
                            crc       <= crc8_next(crc, pf);
`endif
                            // the final frame byte leaves the address parked at FRAME_BYTES-1
                            if (frame_cnt != LAST_M1) begin
                                addr    <= addr + ADDR_W'(1);
                                rd_pend <= {rd_pend[0], 1'b1};
                            end
                        end
                    end else begin
                        shreg <= {shreg[6:0], 1'b0};
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_spi_frame_tx.sv
// Bench for spi_frame_tx: directed scenarios plus random transactions against a byte-level model.
`timescale 1ns/1ps
module tb_spi_frame_tx;
    localparam int FRAME_BYTES = 4;
    localparam int ADDR_W      = 3;
`ifdef SPI_TX_CRC_EN
    localparam int CRC_EXTRA = 1;
`else
    localparam int CRC_EXTRA = 0;
`endif

    logic              sys_clk     = 1'b0;
    logic              sys_rst_n   = 1'b0;
    logic              spi_sclk    = 1'b0;
    logic              spi_cs_n    = 1'b1;
    logic              frame_ready = 1'b0;
    logic              spi_miso, spi_miso_oe, tx_busy, tx_done, tx_abort;
    logic [ADDR_W-1:0] bram_rd_addr;
    logic [7:0]        bram_rd_data;
    logic [7:0]        mem [0:(1<<ADDR_W)-1];

    int checks = 0, errors = 0;
    int hi_run = 0, lo_run = 0, done_cnt = 0, abort_cnt = 0, rise_total = 0, done_at = 0;
    logic [ADDR_W-1:0] last_addr = '0;
    int          addr_q[$];
    logic [7:0]  rx_q[$];

    always #5 sys_clk = ~sys_clk;
    always @(posedge sys_clk) bram_rd_data <= mem[bram_rd_addr];

    spi_frame_tx #(
        .FRAME_BYTES (FRAME_BYTES),
        .ADDR_W      (ADDR_W),
        .HDR_ACK     (8'hA5),
        .HDR_NACK    (8'h00),
        .FILL_BYTE   (8'hFF)
    ) dut (
        .sys_clk      (sys_clk),
        .sys_rst_n    (sys_rst_n),
        .spi_sclk     (spi_sclk),
        .spi_cs_n     (spi_cs_n),
        .spi_miso     (spi_miso),
        .spi_miso_oe  (spi_miso_oe),
        .frame_ready  (frame_ready),
        .bram_rd_addr (bram_rd_addr),
        .bram_rd_data (bram_rd_data),
        .tx_busy      (tx_busy),
        .tx_done      (tx_done),
        .tx_abort     (tx_abort)
    );

    task automatic check_eq(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Reference CRC-8 (poly 0x07) as bitwise polynomial division over the frame bits.
    function automatic logic [7:0] crc8_model();
        logic [7:0] c = 8'h00;
        logic       fb;
        for (int j = 0; j < FRAME_BYTES; j++)
            for (int b = 7; b >= 0; b--) begin
                fb = c[7] ^ mem[j][b];
                c  = {c[6:0], 1'b0};
                if (fb) c = c ^ 8'h07;
            end
        return c;
    endfunction

    function automatic int final_n();
        return FRAME_BYTES + 1 + CRC_EXTRA;
    endfunction

    function automatic logic [7:0] exp_byte(input int k, input logic rdy);
        if (k == 0) return rdy ? 8'hA5 : 8'h00;
        if (!rdy) return 8'hFF;
        if (k <= FRAME_BYTES) return mem[k-1];
        if (CRC_EXTRA == 1 && k == FRAME_BYTES + 1) return crc8_model();
        return 8'hFF;
    endfunction

    // Per-cycle observation and invariant checks, sampled on the falling sys_clk edge.
    task automatic tick();
        @(negedge sys_clk);
        if (!sys_rst_n)     begin hi_run = 0; lo_run = 0; end
        else if (spi_cs_n)  begin hi_run++; lo_run = 0; end
        else                begin lo_run++; hi_run = 0; end
        if (tx_done) begin done_cnt++; done_at = rise_total; end
        if (tx_abort) abort_cnt++;
        if (bram_rd_addr != last_addr) begin
            addr_q.push_back(int'(bram_rd_addr));
            last_addr = bram_rd_addr;
        end
        if (sys_rst_n) begin
            if (hi_run >= 3) begin
                check_eq("idle_oe", spi_miso_oe, 0);
                check_eq("idle_miso", spi_miso, 0);
            end
            if (hi_run >= 4) check_eq("idle_busy", tx_busy, 0);
            if (lo_run >= 4) begin
                check_eq("active_oe", spi_miso_oe, 1);
                check_eq("active_busy", tx_busy, 1);
            end
            check_eq("addr_range", bram_rd_addr <= FRAME_BYTES - 1, 1);
            check_eq("done_abort_excl", tx_done & tx_abort, 0);
        end
    endtask

    task automatic clock_bit(output logic b);
        b = spi_miso;
        spi_sclk = 1'b1;
        rise_total++;
        repeat (4) tick();
        spi_sclk = 1'b0;
        repeat (4) tick();
    endtask

    task automatic run_tx(input string name, input logic rdy, input int nbits);
        int d0, a0, r0, inc;
        logic b, exp_done;
        logic [7:0] cur;
        d0 = done_cnt; a0 = abort_cnt; r0 = rise_total; cur = 8'h00;
        rx_q.delete(); addr_q.delete();
        frame_ready = rdy;
        spi_cs_n = 1'b0;
        repeat (8) tick();
        frame_ready = ~rdy;
        for (int i = 0; i < nbits; i++) begin
            clock_bit(b);
            cur = {cur[6:0], b};
            if (i % 8 == 7) rx_q.push_back(cur);
        end
        spi_cs_n = 1'b1;
        repeat (8) tick();
        for (int k = 0; k < rx_q.size(); k++)
            check_eq($sformatf("%s rx[%0d]", name, k), rx_q[k], exp_byte(k, rdy));
        exp_done = rdy && (nbits >= 8 * final_n());
        check_eq({name, " done_cnt"}, done_cnt - d0, exp_done);
        check_eq({name, " abort_cnt"}, abort_cnt - a0, !exp_done);
        if (exp_done) check_eq({name, " done_timing"}, done_at - r0, 8 * final_n());
        inc = rdy ? ((nbits / 8 < FRAME_BYTES - 1) ? nbits / 8 : FRAME_BYTES - 1) : 0;
        check_eq({name, " addr_changes"}, addr_q.size(), inc + ((inc > 0) ? 1 : 0));
        for (int j = 0; j < inc && j < addr_q.size(); j++)
            check_eq($sformatf("%s addr[%0d]", name, j), addr_q[j], j + 1);
        check_eq({name, " end_busy"}, tx_busy, 0);
    endtask

    task automatic check_all_zero(input string name);
        check_eq({name, " miso"}, spi_miso, 0);
        check_eq({name, " miso_oe"}, spi_miso_oe, 0);
        check_eq({name, " addr"}, bram_rd_addr, 0);
        check_eq({name, " busy"}, tx_busy, 0);
        check_eq({name, " done"}, tx_done, 0);
        check_eq({name, " abort"}, tx_abort, 0);
    endtask

    initial begin
        logic [7:0] t1_exp [0:6];
        logic b;
        int d0, a0;
`ifdef SPI_TX_CRC_EN
        t1_exp = '{8'hA5, 8'h01, 8'h02, 8'h03, 8'h04, 8'hE3, 8'hFF};
`else
        t1_exp = '{8'hA5, 8'h01, 8'h02, 8'h03, 8'h04, 8'hFF, 8'hFF};
`endif
        for (int i = 0; i < (1 << ADDR_W); i++) mem[i] = (i < FRAME_BYTES) ? 8'(i + 1) : 8'h00;

        repeat (3) tick();
        #1 check_all_zero("reset");
        sys_rst_n = 1'b1;
        repeat (4) tick();
        check_all_zero("post_reset");

        // T1 (and T2 under CRC): full frame plus trailing fill
        run_tx("T1", 1'b1, 56);
        check_eq("T1 rx_count", rx_q.size(), 7);
        for (int k = 0; k < 7 && k < rx_q.size(); k++)
            check_eq($sformatf("T1 literal[%0d]", k), rx_q[k], t1_exp[k]);

        // T3: NACK header then fill, no BRAM traffic
        run_tx("T3", 1'b0, 24);
        check_eq("T3 rx1", rx_q.size() > 1 ? rx_q[1] : 8'h55, 8'hFF);

        // T4: early CS rise, then a clean restart
        run_tx("T4", 1'b1, 16);
        run_tx("T4 restart", 1'b1, 16);
        check_eq("T4 restart hdr", rx_q.size() > 0 ? rx_q[0] : 8'h55, 8'hA5);

        // CS glitch of one cycle counts as an abort
        d0 = done_cnt; a0 = abort_cnt;
        spi_cs_n = 1'b0;
        tick();
        spi_cs_n = 1'b1;
        repeat (8) tick();
        check_eq("glitch abort", abort_cnt - a0, 1);
        check_eq("glitch done", done_cnt - d0, 0);

        // T5: reset mid-byte
        frame_ready = 1'b1;
        spi_cs_n = 1'b0;
        repeat (8) tick();
        a0 = abort_cnt;
        for (int i = 0; i < 12; i++) clock_bit(b);
        spi_sclk = 1'b1;
        repeat (2) tick();
        sys_rst_n = 1'b0;
        #1 check_all_zero("T5 reset");
        repeat (3) tick();
        spi_sclk = 1'b0;
        spi_cs_n = 1'b1;
        repeat (3) tick();
        sys_rst_n = 1'b1;
        repeat (8) tick();
        check_eq("T5 no_abort", abort_cnt - a0, 0);
        run_tx("T5 restart", 1'b1, 16);

        // T6: SCLK toggling while deselected
        d0 = done_cnt; a0 = abort_cnt; addr_q.delete();
        for (int i = 0; i < 16; i++) clock_bit(b);
        check_eq("T6 done", done_cnt - d0, 0);
        check_eq("T6 abort", abort_cnt - a0, 0);
        check_eq("T6 addr", addr_q.size(), 0);

        // randomized frames, readiness and transfer lengths
        for (int t = 0; t < 24; t++) begin
            for (int m = 0; m < FRAME_BYTES; m++) mem[m] = 8'($urandom);
            run_tx($sformatf("R%0d", t), 1'($urandom_range(0, 1)), $urandom_range(1, 64));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
